// File: rtl/counter_seq_pkg.sv
// ----------------------------------------------------------------------------
// counter_seq_pkg: command op encodings and FSM state type for counter_sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package counter_seq_pkg;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_RUN   = 2'b10;
  localparam logic [1:0] OP_ABORT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
// ----------------------------------------------------------------------------
// tick_prescaler: free-running divider producing one tick every (period+1) clocks
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tick_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PRESC_W-1:0] period_i,
  input  logic               clear_i,
  input  logic               run_i,
  output logic               tick_o
);

  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] presc_d;

  assign tick_o = run_i && (presc_q == period_i);

  always_comb begin
    presc_d = presc_q;
    if (clear_i) begin
      presc_d = '0;
    end else if (run_i) begin
      presc_d = tick_o ? '0 : presc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/counter_sequencer.sv
// ----------------------------------------------------------------------------
// counter_sequencer: host-command FSM driving a counter's load/enable controls
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [WIDTH-1:0]   cmd_data,
  input  logic [PRESC_W-1:0] cmd_period,
  input  logic [WIDTH-1:0]   cnt_value,
  output logic               cnt_load,
  output logic [WIDTH-1:0]   cnt_load_val,
  output logic               cnt_en,
  output logic               busy,
  output logic               done,
  output logic               err
);

  state_e             state_q,    state_d;
  logic [WIDTH-1:0]   load_val_q, load_val_d;
  logic [WIDTH-1:0]   target_q,   target_d;
  logic [PRESC_W-1:0] period_q,   period_d;
  // One extra bit so the watchdog can hold the full 2^WIDTH enable count.
  logic [WIDTH:0]     wd_q,       wd_d;

  logic w_accept;
  logic w_match;
  logic w_abort;
  logic w_tick;
  logic w_presc_clear;
  logic w_presc_run;

  assign cmd_ready     = !rst && (state_q == ST_IDLE || state_q == ST_RUN);
  assign w_accept      = cmd_valid && cmd_ready;
  assign w_match       = (cnt_value == target_q);
  assign w_abort       = w_accept && (state_q == ST_RUN) && (cmd_op == OP_ABORT);
  assign w_presc_clear = w_accept && (state_q == ST_IDLE) && (cmd_op == OP_RUN);
  assign w_presc_run   = (state_q == ST_RUN) && !w_match;

  tick_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk      (clk),
    .rst      (rst),
    .period_i (period_q),
    .clear_i  (w_presc_clear),
    .run_i    (w_presc_run),
    .tick_o   (w_tick)
  );

  assign cnt_load     = (state_q == ST_LOAD);
  assign cnt_load_val = load_val_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);

  always_comb begin
    state_d    = state_q;
    load_val_d = load_val_q;
    target_d   = target_q;
    period_d   = period_q;
    wd_d       = wd_q;
    cnt_en     = 1'b0;
    err        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          case (cmd_op)
            OP_LOAD: begin
              load_val_d = cmd_data;
              state_d    = ST_LOAD;
            end
            OP_RUN: begin
              target_d = cmd_data;
              period_d = cmd_period;
              wd_d     = '0;
              state_d  = ST_RUN;
            end
            default: ;
          endcase
        end
      end
      ST_LOAD: state_d = ST_DONE;
      ST_RUN: begin
        // Any non-abort command is rejected but the run keeps going.
        err = w_accept && (cmd_op != OP_ABORT);
        if (w_abort) begin
          state_d = ST_IDLE;
        end else if (w_match) begin
          state_d = ST_DONE;
        end else if (wd_q[WIDTH]) begin
          err     = 1'b1;
          state_d = ST_IDLE;
        end else if (w_tick) begin
          cnt_en = 1'b1;
          wd_d   = wd_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      load_val_q <= '0;
      target_q   <= '0;
      period_q   <= '0;
      wd_q       <= '0;
    end else begin
      state_q    <= state_d;
      load_val_q <= load_val_d;
      target_q   <= target_d;
      period_q   <= period_d;
      wd_q       <= wd_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_counter_sequencer.sv
// ----------------------------------------------------------------------------
// tb_counter_sequencer: scoreboard bench with a behavioural counter datapath
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_counter_sequencer;
  import counter_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = OP_NOP;
  logic [7:0] cmd_data = 8'h00;
  logic [7:0] cmd_period = 8'h00;
  logic [7:0] cnt_value = 8'h00;
  logic       cnt_load;
  logic [7:0] cnt_load_val;
  logic       cnt_en;
  logic       busy;
  logic       done;
  logic       err;
  logic       stuck = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  counter_sequencer #(.WIDTH(8), .PRESC_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .cmd_period   (cmd_period),
    .cnt_value    (cnt_value),
    .cnt_load     (cnt_load),
    .cnt_load_val (cnt_load_val),
    .cnt_en       (cnt_en),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  // Counter datapath model; 'stuck' freezes it to exercise the watchdog.
  always @(posedge clk) begin
    if (cnt_load)               cnt_value <= cnt_load_val;
    else if (cnt_en && !stuck)  cnt_value <= cnt_value + 8'd1;
  end

  typedef struct {
    int n_en; int n_load; int n_done; int n_err;
    int first; int gap; int fin; int lval;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  int s_en, s_load, s_done, s_err, s_first, s_last, s_gmin, s_gmax, s_cyc, s_lval;
  bit s_excl, s_busy;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
  endtask

  task automatic push_exp(input string tag, input int en, input int ld, input int dn,
                          input int er, input int first, input int gap, input int fin,
                          input int lval);
    exp_t e;
    e.n_en = en; e.n_load = ld; e.n_done = dn; e.n_err = er;
    e.first = first; e.gap = gap; e.fin = fin; e.lval = lval;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] data, input logic [7:0] per);
    int w = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_period = per;
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check_eq("send_ready", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_op = OP_NOP;
  endtask

  task automatic tally();
    if ((cnt_en || cnt_load) && s_first < 0) s_first = s_cyc;
    if (cnt_en) begin
      if (s_last >= 0) begin
        if (s_cyc - s_last < s_gmin) s_gmin = s_cyc - s_last;
        if (s_cyc - s_last > s_gmax) s_gmax = s_cyc - s_last;
      end
      s_last = s_cyc;
      s_en++;
    end
    if (cnt_load) begin s_load++; s_lval = int'(cnt_load_val); end
    if (done) s_done++;
    if (err)  s_err++;
    if (cnt_en && cnt_load) s_excl = 1'b1;
    s_busy = busy;
    s_cyc++;
  endtask

  // Observes one transaction from the cycle after acceptance until busy drops,
  // optionally injecting a command once inj_at enables have been seen.
  task automatic run_txn(input int inj_at, input logic [1:0] inj_op, input int max_cyc);
    exp_t  e;
    string tg;
    bit    injected = 1'b0;
    bit    fin = 1'b0;
    int    gap;
    s_en = 0; s_load = 0; s_done = 0; s_err = 0; s_first = -1; s_last = -1;
    s_gmin = 1000; s_gmax = -1; s_cyc = 0; s_lval = -1; s_excl = 1'b0; s_busy = 1'b1;
    while (!fin && s_cyc < max_cyc) begin
      if (inj_at >= 0 && !injected && s_en == inj_at && s_busy && s_cyc > 0) begin
        @(posedge clk);
        #1;
        cmd_valid = 1'b1; cmd_op = inj_op; cmd_data = 8'hC3; cmd_period = 8'h00;
        injected = 1'b1;
        @(negedge clk);
        check_eq("inj_ready", cmd_ready, 1);
        check_eq("inj_err", err, (inj_op != OP_ABORT));
        check_eq("inj_noload", cnt_load, 0);
        if (inj_op == OP_ABORT) check_eq("abort_en0", cnt_en, 0);
        tally();
        @(posedge clk);
        #1;
        cmd_valid = 1'b0; cmd_op = OP_NOP;
      end else begin
        @(negedge clk);
        tally();
      end
      if (!s_busy) fin = 1'b1;
    end
    gap = (s_en < 2) ? -1 : ((s_gmin == s_gmax) ? s_gmin : -2);
    e  = exp_q.pop_front();
    tg = tag_q.pop_front();
    check_eq({tg, ".end"},   fin, 1);
    check_eq({tg, ".en"},    s_en, e.n_en);
    check_eq({tg, ".load"},  s_load, e.n_load);
    check_eq({tg, ".done"},  s_done, e.n_done);
    check_eq({tg, ".err"},   s_err, e.n_err);
    check_eq({tg, ".first"}, s_first, e.first);
    check_eq({tg, ".gap"},   gap, e.gap);
    check_eq({tg, ".count"}, cnt_value, e.fin);
    check_eq({tg, ".lval"},  s_lval, e.lval);
    check_eq({tg, ".excl"},  s_excl, 0);
  endtask

  task automatic do_load(input string tag, input logic [7:0] v);
    push_exp(tag, 0, 1, 1, 0, 0, -1, int'(v), int'(v));
    send(OP_LOAD, v, 8'h00);
    run_txn(-1, OP_NOP, 20);
  endtask

  task automatic do_run(input string tag, input logic [7:0] tgt, input logic [7:0] per,
                        input int inj_at, input logic [1:0] inj_op, input int n_en,
                        input int n_err, input int n_done, input logic [7:0] fin);
    push_exp(tag, n_en, 0, n_done, n_err, (n_en > 0) ? int'(per) : -1,
             (n_en >= 2) ? int'(per) + 1 : -1, int'(fin), -1);
    send(OP_RUN, tgt, per);
    run_txn(inj_at, inj_op, 600);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_ready", cmd_ready, 0);
    check_eq("rst_outs", {cnt_load, cnt_en, busy, done, err}, 5'b0);
    check_eq("rst_lval", cnt_load_val, 8'h00);
    rst = 1'b0;
    #1;
    check_eq("post_rst_ready", cmd_ready, 1);

    do_load("T2_load5A", 8'h5A);
    check_eq("T2_hold_lval", cnt_load_val, 8'h5A);

    send(OP_NOP, 8'h00, 8'h00);
    @(negedge clk);
    check_eq("nop_idle", {busy, done, err, cnt_load, cnt_en}, 5'b0);

    do_load("T3_load10", 8'h10);
    do_run("T3_run", 8'h14, 8'd0, -1, OP_NOP, 4, 0, 1, 8'h14);

    do_load("T4_loadFE", 8'hFE);
    do_run("T4_wrap", 8'h01, 8'd2, -1, OP_NOP, 3, 0, 1, 8'h01);

    do_load("T5_load00", 8'h00);
    do_run("T5_abort", 8'h80, 8'd0, 5, OP_ABORT, 5, 0, 0, 8'h05);

    do_load("T6_load20", 8'h20);
    do_run("T6_cmd_err", 8'h28, 8'd1, 3, OP_LOAD, 8, 1, 1, 8'h28);

    stuck = 1'b1;
    do_run("T6_watchdog", 8'h00, 8'd0, -1, OP_NOP, 256, 0 + 1, 0, 8'h28);
    stuck = 1'b0;

    do_run("run_at_target", 8'h28, 8'd3, -1, OP_NOP, 0, 0, 1, 8'h28);

    send(OP_RUN, 8'h80, 8'd3);
    repeat (10) @(negedge clk);
    check_eq("T1_busy_before", busy, 1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_eq("T1_rst_outs", {cnt_load, cnt_en, busy, done, err}, 5'b0);
    check_eq("T1_rst_lval", cnt_load_val, 8'h00);
    check_eq("T1_rst_ready", cmd_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("T1_ready_after", cmd_ready, 1);
    check_eq("T1_idle_after", busy, 0);
    @(negedge clk);
    check_eq("T1_no_resume", {busy, cnt_en}, 2'b00);

    do_load("post_reset_load", 8'h33);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
